arb_weight_tracker: RTL and testbench

- Sequential companion to the arbiter's combinational priority granter.
- Counts handshakes accepted per requester against a per-requester weight.
- Drives the `request_weight_completed` vector back into the granter.
- Clears the weight round once no uncompleted requester is still requesting. Sits beside the granter in each interconnect arbiter: AW, AR, W-order and B/R return.

---
 rtl/arb_weight_tracker.sv | 150 +++++++++++++++
 tb/tb_arb_weight_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/arb_weight_tracker.sv
// Weight tracker paired with the arbiter's combinational priority granter.
// Counts accepted handshakes per requester against a per-requester weight and
// reports which requesters have used their weight in the current round. The
// round clears once no uncompleted requester is still requesting.
// Optional build macro: ARB_WEIGHT_CHECK_EN adds a sticky grant_err output.
module arb_weight_tracker #(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_WEIGHT_W      = 4
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETn,
  input  logic [P_REQUESTER_NUM-1:0]            request,
  input  logic [P_REQUESTER_NUM-1:0]            grant,
  input  logic                                  handshake,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight,
  output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
`ifdef ARB_WEIGHT_CHECK_EN
  output logic                                  grant_err,
`endif
  output logic                                  round_done
);

  // One extra bit so cnt+1 never wraps before the compare.
  localparam int unsigned LP_CW = P_WEIGHT_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  state_e                      r_state;
  logic [P_WEIGHT_W-1:0]       r_cnt [P_REQUESTER_NUM];
  logic [P_REQUESTER_NUM-1:0]  r_completed;
  logic                        r_round_done;

  logic [P_WEIGHT_W-1:0]       w_eff_w     [P_REQUESTER_NUM];
  logic [LP_CW-1:0]            w_cnt_inc   [P_REQUESTER_NUM];
  logic [P_WEIGHT_W-1:0]       w_cnt_nxt   [P_REQUESTER_NUM];
  logic [P_REQUESTER_NUM-1:0]  w_completed_nxt;
  logic [P_REQUESTER_NUM-1:0]  w_grant_sel;
  logic [P_REQUESTER_NUM-1:0]  w_acc;
  logic [P_REQUESTER_NUM-1:0]  w_pending;
  logic                        w_clr;

  // Effective weight: a zero weight behaves as one.
  always_comb begin
    for (int i = 0; i < int'(P_REQUESTER_NUM); i++) begin
      w_eff_w[i] = (weight[i*P_WEIGHT_W +: P_WEIGHT_W] == '0) ? P_WEIGHT_W'(1)
                                                              : weight[i*P_WEIGHT_W +: P_WEIGHT_W];
    end
  end

  // Keep only the lowest-index grant bit so a malformed grant counts once.
  always_comb begin
    logic found;
    found       = 1'b0;
    w_grant_sel = '0;
    for (int i = 0; i < int'(P_REQUESTER_NUM); i++) begin
      w_grant_sel[i] = grant[i] & ~found;
      found          = found | grant[i];
    end
  end

  assign w_acc     = {P_REQUESTER_NUM{handshake}} & w_grant_sel;
  assign w_pending = request & ~r_completed;
  // Round clears once something completed and nobody uncompleted still asks.
  assign w_clr     = (|r_completed) & ~(|w_pending);

  // Next-state for counters and completion bits.
  always_comb begin
    w_completed_nxt = r_completed;
    for (int i = 0; i < int'(P_REQUESTER_NUM); i++) begin
      w_cnt_inc[i] = {1'b0, r_cnt[i]} + LP_CW'(1);
      w_cnt_nxt[i] = r_cnt[i];
      if (w_clr) begin
        // New round; a same-cycle accept becomes the first count of it.
        w_cnt_nxt[i]       = w_acc[i] ? P_WEIGHT_W'(1) : '0;
        w_completed_nxt[i] = w_acc[i] & (w_eff_w[i] == P_WEIGHT_W'(1));
      end else if (w_acc[i] && !r_completed[i]) begin
        if (w_cnt_inc[i] >= {1'b0, w_eff_w[i]}) begin
          w_cnt_nxt[i]       = w_eff_w[i];
          w_completed_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = w_cnt_inc[i][P_WEIGHT_W-1:0];
        end
      end
    end
  end

  // Counter, completion and round_done registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(P_REQUESTER_NUM); i++) begin
        r_cnt[i] <= '0;
      end
      r_completed  <= '0;
      r_round_done <= 1'b0;
    end else begin
      for (int i = 0; i < int'(P_REQUESTER_NUM); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_completed  <= w_completed_nxt;
      r_round_done <= w_clr;
    end
  end

  // Round state: idle while all counters are zero, active otherwise.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_acc) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_clr && !(|w_acc)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign request_weight_completed = r_completed;
  assign round_done               = r_round_done;

`ifdef ARB_WEIGHT_CHECK_EN
  logic r_grant_err;
  logic w_grant_err_evt;

  // Multi-hot grant on a handshake, or a grant to a non-requester.
  assign w_grant_err_evt = (handshake & (|(grant & ~w_grant_sel))) | (|(grant & ~request));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_grant_err <= 1'b0;
    end else if (w_grant_err_evt) begin
      r_grant_err <= 1'b1;
    end
  end

  assign grant_err = r_grant_err;
`endif

endmodule

// File: tb/tb_arb_weight_tracker.sv
// Directed, table-driven bench for arb_weight_tracker (3 requesters, 4-bit weights).
module tb_arb_weight_tracker;

  localparam int unsigned N = 3;
  localparam int unsigned W = 4;
  localparam int          NVEC = 34;

  logic           ACLK;
  logic           ARESETn;
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           handshake;
  logic [N*W-1:0] weight;
  logic [N-1:0]   completed;
  logic           round_done;
`ifdef ARB_WEIGHT_CHECK_EN
  logic           grant_err;
`endif

  arb_weight_tracker #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W)
  ) u_dut (
    .ACLK                     (ACLK),
    .ARESETn                  (ARESETn),
    .request                  (request),
    .grant                    (grant),
    .handshake                (handshake),
    .weight                   (weight),
    .request_weight_completed (completed),
`ifdef ARB_WEIGHT_CHECK_EN
    .grant_err                (grant_err),
`endif
    .round_done               (round_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           hs;
    logic [N*W-1:0] wt;
    logic [N-1:0]   exp_c;
    logic           exp_rd;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] gnt, input logic hs,
                       input logic [N*W-1:0] wt);
    @(negedge ACLK);
    request   = req;
    grant     = gnt;
    handshake = hs;
    weight    = wt;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // weights {w2,w1,w0}: 121 -> {1,2,1}, 101 -> {1,0,1}, 131 -> {1,3,1}, 112 -> {1,1,2}
    // Round with weights {1,2,1}, plus an exception-path accept on row 1.
    vecs[0]  = '{3'b111, 3'b001, 1'b1, 12'h121, 3'b001, 1'b0};
    vecs[1]  = '{3'b111, 3'b001, 1'b1, 12'h121, 3'b001, 1'b0};
    vecs[2]  = '{3'b111, 3'b010, 1'b1, 12'h121, 3'b001, 1'b0};
    vecs[3]  = '{3'b111, 3'b010, 1'b1, 12'h121, 3'b011, 1'b0};
    vecs[4]  = '{3'b111, 3'b100, 1'b1, 12'h121, 3'b111, 1'b0};
    vecs[5]  = '{3'b111, 3'b000, 1'b0, 12'h121, 3'b000, 1'b1};
    vecs[6]  = '{3'b111, 3'b000, 1'b0, 12'h121, 3'b000, 1'b0};
    // Zero weight behaves as one; handshake with no grant is ignored.
    vecs[7]  = '{3'b111, 3'b010, 1'b1, 12'h101, 3'b010, 1'b0};
    vecs[8]  = '{3'b111, 3'b000, 1'b1, 12'h101, 3'b010, 1'b0};
    vecs[9]  = '{3'b111, 3'b001, 1'b1, 12'h101, 3'b011, 1'b0};
    vecs[10] = '{3'b111, 3'b100, 1'b1, 12'h101, 3'b111, 1'b0};
    vecs[11] = '{3'b111, 3'b000, 1'b0, 12'h101, 3'b000, 1'b1};
    // Single requester, weight 3; second round proves the counter cleared.
    vecs[12] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b000, 1'b0};
    vecs[13] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b000, 1'b0};
    vecs[14] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b010, 1'b0};
    vecs[15] = '{3'b010, 3'b000, 1'b0, 12'h131, 3'b000, 1'b1};
    vecs[16] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b000, 1'b0};
    vecs[17] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b000, 1'b0};
    vecs[18] = '{3'b010, 3'b010, 1'b1, 12'h131, 3'b010, 1'b0};
    vecs[19] = '{3'b010, 3'b000, 1'b0, 12'h131, 3'b000, 1'b1};
    // Clear cycle coincides with an accept on requester 0 (weight 2).
    vecs[20] = '{3'b011, 3'b001, 1'b1, 12'h112, 3'b000, 1'b0};
    vecs[21] = '{3'b011, 3'b001, 1'b1, 12'h112, 3'b001, 1'b0};
    vecs[22] = '{3'b011, 3'b010, 1'b1, 12'h112, 3'b011, 1'b0};
    vecs[23] = '{3'b011, 3'b001, 1'b1, 12'h112, 3'b000, 1'b1};
    vecs[24] = '{3'b011, 3'b001, 1'b1, 12'h112, 3'b001, 1'b0};
    vecs[25] = '{3'b011, 3'b010, 1'b1, 12'h112, 3'b011, 1'b0};
    vecs[26] = '{3'b011, 3'b000, 1'b0, 12'h112, 3'b000, 1'b1};
    vecs[27] = '{3'b011, 3'b000, 1'b0, 12'h112, 3'b000, 1'b0};
    // Requester 1 drops request mid-round; its partial count is retained.
    vecs[28] = '{3'b111, 3'b010, 1'b1, 12'h121, 3'b000, 1'b0};
    vecs[29] = '{3'b101, 3'b001, 1'b1, 12'h121, 3'b001, 1'b0};
    vecs[30] = '{3'b101, 3'b100, 1'b1, 12'h121, 3'b101, 1'b0};
    vecs[31] = '{3'b111, 3'b000, 1'b0, 12'h121, 3'b101, 1'b0};
    vecs[32] = '{3'b111, 3'b010, 1'b1, 12'h121, 3'b111, 1'b0};
    vecs[33] = '{3'b111, 3'b000, 1'b0, 12'h121, 3'b000, 1'b1};

    request   = '0;
    grant     = '0;
    handshake = 1'b0;
    weight    = 12'h121;
    ARESETn   = 1'b1;
    #2 ARESETn = 1'b0;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    check("reset completed", 32'(completed), 32'h0);
    check("reset round_done", 32'(round_done), 32'h0);
`ifdef ARB_WEIGHT_CHECK_EN
    check("reset grant_err", 32'(grant_err), 32'h0);
`endif
    @(negedge ACLK);
    ARESETn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].hs, vecs[i].wt);
      @(posedge ACLK);
      #1;
      check($sformatf("row%0d completed", i), 32'(completed), 32'(vecs[i].exp_c));
      check($sformatf("row%0d round_done", i), 32'(round_done), 32'(vecs[i].exp_rd));
    end

`ifdef ARB_WEIGHT_CHECK_EN
    check("grant_err clean after legal traffic", 32'(grant_err), 32'h0);
`endif

    // Multi-hot grant: only requester 0 counts.
    drive(3'b111, 3'b011, 1'b1, 12'h111);
    @(posedge ACLK);
    #1;
    check("multihot completed", 32'(completed), 32'h1);
    check("multihot round_done", 32'(round_done), 32'h0);
`ifdef ARB_WEIGHT_CHECK_EN
    check("multihot grant_err set", 32'(grant_err), 32'h1);
`endif
    drive(3'b111, 3'b010, 1'b1, 12'h111);
    @(posedge ACLK);
    #1;
    check("pre-reset completed", 32'(completed), 32'h3);
`ifdef ARB_WEIGHT_CHECK_EN
    check("grant_err sticky", 32'(grant_err), 32'h1);
`endif

    // Asynchronous reset mid-round with completed=011.
    drive(3'b111, 3'b000, 1'b0, 12'h111);
    ARESETn = 1'b0;
    #1;
    check("async reset completed", 32'(completed), 32'h0);
    check("async reset round_done", 32'(round_done), 32'h0);
`ifdef ARB_WEIGHT_CHECK_EN
    check("async reset grant_err", 32'(grant_err), 32'h0);
`endif
    @(posedge ACLK);
    #1;
    check("in reset round_done", 32'(round_done), 32'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    check("post reset completed", 32'(completed), 32'h0);
    check("post reset round_done", 32'(round_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
